// File: rtl/sysid_checker.sv
// rtl/sysid_checker.sv - reads sysid word 0/1 over Avalon-MM and checks them against expected build values
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1463519144,
    parameter int          TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        restart,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_ID = 3'd1,
        S_WT_ID = 3'd2,
        S_RD_TS = 3'd3,
        S_WT_TS = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // cnt_q counts completed cycles of the current read, so the cycle where it
    // equals TIMEOUT_CYCLES-1 is the last one allowed
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] id_q, id_d;
    logic [31:0] ts_q, ts_d;
    logic        pass_q, pass_d;
    logic        timeout_q, timeout_d;
    logic        expired;

    assign expired = (cnt_q == TO_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            id_q      <= 32'd0;
            ts_q      <= 32'd0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            id_q      <= id_d;
            ts_q      <= ts_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        ts_d      = ts_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_RD_ID;
                cnt_d   = 16'd0;
            end
            S_RD_ID, S_RD_TS: begin
                cnt_d = cnt_q + 16'd1;
                if (expired) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end else if (!avm_waitrequest) begin
                    state_d = (state_q == S_RD_ID) ? S_WT_ID : S_WT_TS;
                end
            end
            S_WT_ID: begin
                cnt_d = cnt_q + 16'd1;
                // a capture on the final allowed cycle still counts as success
                if (avm_readdatavalid) begin
                    id_d    = avm_readdata;
                    state_d = S_RD_TS;
                    cnt_d   = 16'd0;
                end else if (expired) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end
            end
            S_WT_TS: begin
                cnt_d = cnt_q + 16'd1;
                if (avm_readdatavalid) begin
                    ts_d      = avm_readdata;
                    state_d   = S_DONE;
                    timeout_d = 1'b0;
                    pass_d    = (id_q == EXPECTED_ID) && (avm_readdata == EXPECTED_TIMESTAMP);
                end else if (expired) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end
            end
            S_DONE: begin
                if (restart) begin
                    state_d   = S_RD_ID;
                    cnt_d     = 16'd0;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        avm_read    = (state_q == S_RD_ID) || (state_q == S_RD_TS);
        avm_address = (state_q == S_RD_TS);
        busy        = (state_q == S_RD_ID) || (state_q == S_WT_ID) ||
                      (state_q == S_RD_TS) || (state_q == S_WT_TS);
        done        = (state_q == S_DONE);
        pass        = pass_q;
        timeout     = timeout_q;
        id_value    = id_q;
        ts_value    = ts_q;
    end

endmodule

// File: tb/tb_sysid_checker.sv
// tb/tb_sysid_checker.sv - scoreboard bench for sysid_checker with a configurable Avalon-MM slave
module tb_sysid_checker;

    localparam logic [31:0] TS = 32'd1463519144;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        restart;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic [31:0] id_value;
    logic [31:0] ts_value;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;

    sysid_checker #(
        .EXPECTED_ID       (32'd0),
        .EXPECTED_TIMESTAMP(TS),
        .TIMEOUT_CYCLES    (8)
    ) u_dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .restart          (restart),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .id_value         (id_value),
        .ts_value         (ts_value),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .timeout          (timeout)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic        pass;
        logic        to;
        logic [31:0] id;
        logic [31:0] ts;
        int          accepts;
        int          busy_cycles;
    } exp_t;

    exp_t sb_q[$];
    logic addr_q[$];

    // slave model
    int          wait_cfg = 0;
    int          lat_cfg  = 1;
    logic [31:0] id_word  = 32'd0;
    logic [31:0] ts_word  = TS;
    logic        resp_id  = 1'b1;
    logic        resp_ts  = 1'b1;
    int          wr_cnt   = 0;
    logic        pend     = 1'b0;
    int          timer    = 0;
    logic [31:0] rsp_data = 32'd0;

    assign avm_waitrequest   = avm_read && (wr_cnt < wait_cfg);
    assign avm_readdatavalid = pend && (timer == 0);
    assign avm_readdata      = avm_readdatavalid ? rsp_data : 32'hdeadbeef;

    always @(posedge clock) begin
        if (avm_readdatavalid) pend <= 1'b0;
        else if (pend) timer <= timer - 1;
        if (avm_read) begin
            if (avm_waitrequest) begin
                wr_cnt <= wr_cnt + 1;
            end else begin
                wr_cnt   <= 0;
                pend     <= avm_address ? resp_ts : resp_id;
                timer    <= lat_cfg - 1;
                rsp_data <= avm_address ? ts_word : id_word;
            end
        end
    end

    // monitor: request stability, accepted addresses, and run results
    int   runs = 0;
    int   busy_cnt = 0;
    int   acc_cnt = 0;
    logic prev_wait = 1'b0;
    logic prev_addr = 1'b0;
    logic done_prev = 1'b0;
    exp_t e;

    always @(negedge clock) begin
        if (!reset_n) begin
            busy_cnt  = 0;
            acc_cnt   = 0;
            prev_wait = 1'b0;
            done_prev = 1'b0;
        end else begin
            if (prev_wait) begin
                check_eq("req_held", avm_read, 1'b1);
                check_eq("addr_held", avm_address, prev_addr);
            end
            prev_wait = avm_read && avm_waitrequest;
            prev_addr = avm_address;
            if (avm_read && !avm_waitrequest) begin
                acc_cnt++;
                if (addr_q.size() == 0) check_eq("addr_sb_empty", addr_q.size(), 1);
                else check_eq("accept_addr", avm_address, addr_q.pop_front());
            end
            if (busy) busy_cnt++;
            if (done && !done_prev) begin
                if (sb_q.size() == 0) begin
                    check_eq("result_sb_empty", sb_q.size(), 1);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("pass", pass, e.pass);
                    check_eq("timeout", timeout, e.to);
                    check_eq("id_value", id_value, e.id);
                    check_eq("ts_value", ts_value, e.ts);
                    check_eq("accepts", acc_cnt, e.accepts);
                    check_eq("busy_cycles", busy_cnt, e.busy_cycles);
                    check_eq("busy_with_done", busy, 1'b0);
                end
                runs++;
                busy_cnt = 0;
                acc_cnt  = 0;
            end
            done_prev = done;
        end
    end

    task automatic push_run(input logic p, input logic to, input logic [31:0] id,
                            input logic [31:0] ts, input int acc, input int bc);
        exp_t x;
        x.pass = p; x.to = to; x.id = id; x.ts = ts; x.accepts = acc; x.busy_cycles = bc;
        sb_q.push_back(x);
        addr_q.push_back(1'b0);
        if (acc > 1) addr_q.push_back(1'b1);
    endtask

    task automatic pulse_restart();
        @(negedge clock);
        restart = 1'b1;
        @(negedge clock);
        restart = 1'b0;
    endtask

    task automatic wait_run(input int start);
        int t = 0;
        while (runs == start && t < 300) begin
            @(negedge clock);
            t++;
        end
        check_eq("run_completed", runs - start, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_read"}, avm_read, 1'b0);
        check_eq({tag, "_addr"}, avm_address, 1'b0);
        check_eq({tag, "_id"}, id_value, 32'd0);
        check_eq({tag, "_ts"}, ts_value, 32'd0);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_done"}, done, 1'b0);
        check_eq({tag, "_pass"}, pass, 1'b0);
        check_eq({tag, "_timeout"}, timeout, 1'b0);
    endtask

    initial begin
        int start;
        int t;
        restart = 1'b0;
        #1 reset_n = 1'b0;
        #1 check_reset_outputs("reset");

        // zero-wait slave, matching words
        start = runs;
        push_run(1'b1, 1'b0, 32'd0, TS, 2, 4);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        wait_run(start);
        check_eq("read_low_in_done", avm_read, 1'b0);

        // timestamp off by one
        ts_word = TS + 32'd1;
        start = runs;
        push_run(1'b0, 1'b0, 32'd0, TS + 32'd1, 2, 4);
        pulse_restart();
        wait_run(start);

        // five waitrequest cycles per read
        ts_word  = TS;
        wait_cfg = 5;
        start = runs;
        push_run(1'b1, 1'b0, 32'd0, TS, 2, 14);
        pulse_restart();
        wait_run(start);

        // capture lands on the last allowed cycle
        lat_cfg = 2;
        start = runs;
        push_run(1'b1, 1'b0, 32'd0, TS, 2, 16);
        pulse_restart();
        wait_run(start);

        // word 0 never answered
        wait_cfg = 0;
        lat_cfg  = 1;
        resp_id  = 1'b0;
        start = runs;
        push_run(1'b0, 1'b1, 32'd0, TS, 1, 8);
        pulse_restart();
        wait_run(start);
        repeat (3) @(negedge clock);
        check_eq("read_low_after_timeout", avm_read, 1'b0);
        check_eq("done_held_after_timeout", done, 1'b1);

        // wrong ID, with a restart pulse while busy that must be ignored
        resp_id = 1'b1;
        id_word = 32'd5;
        start = runs;
        push_run(1'b0, 1'b0, 32'd5, TS, 2, 4);
        pulse_restart();
        restart = 1'b1;
        @(negedge clock);
        restart = 1'b0;
        wait_run(start);

        // reset while waiting for word 1; late response must be ignored
        id_word  = 32'h1234;
        wait_cfg = 3;
        lat_cfg  = 4;
        addr_q.push_back(1'b0);
        addr_q.push_back(1'b1);
        pulse_restart();
        t = 0;
        while (!(avm_read && avm_address && !avm_waitrequest) && t < 100) begin
            @(negedge clock);
            t++;
        end
        check_eq("reached_rd_ts_accept", t < 100, 1'b1);
        @(posedge clock);
        #2 reset_n = 1'b0;
        id_word = 32'd0;
        #1 check_reset_outputs("async_reset");
        start = runs;
        push_run(1'b1, 1'b0, 32'd0, TS, 2, 16);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        wait_run(start);

        check_eq("sb_drained", sb_q.size() + addr_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
